reg_to_axi_lite: RTL
====================

Name: reg_to_axi_lite

Overview:
Protocol converter from the register bus (REG_BUS semantics, block is the responder) to AXI4-Lite (block is the manager). It lets register-bus masters such as debug modules and config FSMs reach AXI-Lite peripherals. The block is non-pipelined: it has at most one outstanding transaction, and all AXI outputs are registered.

Parameters:
ADDR_WIDTH, 32, width of reg and AXI addresses
DATA_WIDTH, 32, data width; must be a multiple of 8; strobe width is DATA_WIDTH/8
AXI_PROT, 3'b000, constant driven on aw_prot/ar_prot

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
reg_valid_i  in  1  register request valid
reg_write_i  in  1  1=write, 0=read
reg_addr_i  in  ADDR_WIDTH  request address
reg_wdata_i  in  DATA_WIDTH  write data
reg_wstrb_i  in  DATA_WIDTH/8  write byte strobes
reg_ready_o  out  1  one-cycle completion pulse
reg_rdata_o  out  DATA_WIDTH  read data, valid when reg_ready_o=1
reg_error_o  out  1  error flag, valid when reg_ready_o=1
aw_valid_o/aw_ready_i/aw_addr_o/aw_prot_o  out/in/out/out  1/1/ADDR_WIDTH/3  AXI-Lite AW channel
w_valid_o/w_ready_i/w_data_o/w_strb_o  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  AXI-Lite W channel
b_valid_i/b_ready_o/b_resp_i  in/out/in  1/1/2  AXI-Lite B channel
ar_valid_o/ar_ready_i/ar_addr_o/ar_prot_o  out/in/out/out  1/1/ADDR_WIDTH/3  AXI-Lite AR channel
r_valid_i/r_ready_o/r_data_i/r_resp_i  in/out/in/in  1/1/DATA_WIDTH/2  AXI-Lite R channel

Behaviour:
- Reset: state IDLE. All valid/ready outputs are 0. aw_addr_o, ar_addr_o, w_data_o, w_strb_o, reg_rdata_o and reg_error_o are 0. aw_prot_o/ar_prot_o always equal AXI_PROT.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP, DONE.
- IDLE, reg_valid_i=1:
  - Latch addr, wdata and wstrb into the AXI output registers.
  - Next state is WR_ADDR_DATA if reg_write_i, else RD_ADDR.
  - aw_valid_o+w_valid_o (write) or ar_valid_o (read) go high in the next cycle.
- WR_ADDR_DATA:
  - AW and W are independent. Each valid drops the cycle after its own handshake and is tracked by its own done flag.
  - Payload is held stable while valid is high.
  - Once both handshakes are complete (same or different cycles), go to WR_RESP.
- WR_RESP: b_ready_o=1. On b_valid_i, set reg_error_o<=b_resp_i[1] and reg_rdata_o<='0, then go to DONE.
- RD_ADDR: ar_valid_o held until ar_ready_i, then go to RD_RESP.
- RD_RESP: r_ready_o=1. On r_valid_i, set reg_rdata_o<=r_data_i and reg_error_o<=r_resp_i[1], then go to DONE.
- DONE: reg_ready_o=1 for exactly one cycle, then IDLE. A new request can be accepted in the following cycle.
- Minimum latency with zero-wait AXI slave:
  - Write: request seen at cycle 0, AW/W valid at cycle 1, B at cycle 2, reg_ready_o at cycle 3.
  - Read: same timing, with AR at cycle 1, R at cycle 2, reg_ready_o at cycle 3.
- Responses: OKAY and EXOKAY give error=0; SLVERR and DECERR give error=1.
- Master contract: the reg master holds its request stable until reg_ready_o. Request inputs are sampled only in IDLE.
  - If reg_valid_i drops mid-transaction, the AXI transaction still completes and the DONE pulse is still issued.
- reg_ready_o is never asserted in the same cycle as an AXI handshake.
- Stray b_valid_i or r_valid_i outside the matching *_RESP state is ignored; b_ready_o/r_ready_o stay 0.
- Reset mid-operation: reset wins asynchronously and returns the block to IDLE with all outputs at reset values. Any in-flight AXI transaction is abandoned; the system resets both sides together.
- No timeout. A hung slave stalls the block indefinitely.

Decomposition:
- Add to the shared reg_intf package: AXI response encodings (RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11) and the helper function resp_is_error().
- The FSM state enum stays local to the module.
- No sub-module is needed; the block is a single FSM plus output registers.
- An interface-port wrapper (REG_BUS.in / AXI_LITE.out) is a separate thin file, reg_to_axi_lite_intf.

Test Plan:
1. Write 0xDEADBEEF to 0x40, wstrb 4'hF, slave zero-wait → AW/W valid cycle 1, reg_ready_o cycle 3, error 0.
2. Write with aw_ready_i delayed 3 cycles and w_ready_i immediate → w_valid_o drops after 1 cycle, aw_valid_o held 4 cycles with addr stable, single B, one reg_ready_o pulse.
3. Read 0x80, slave returns r_data 0x12345678 OKAY after 5-cycle delay → reg_rdata_o=0x12345678, error 0, reg_ready_o exactly one cycle.
4. Read returning DECERR, then write returning SLVERR → error=1 both times; rdata=0 on the write.
5. Back-to-back requests (reg_valid_i held high) → second transaction starts the cycle after DONE; no overlap of AXI valids.
6. rst_i asserted while in WR_RESP → all outputs 0 in the same cycle, state IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/reg_to_axi_lite_pkg.sv
// Shared definitions for the register-bus to AXI4-Lite bridge.
//   axi_resp_t     : 2-bit AXI response code
//   RESP_*         : AXI response encodings
//   resp_is_error(): 1 for SLVERR/DECERR, 0 for OKAY/EXOKAY
package reg_to_axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  // The upper bit separates the two error codes from the two success codes.
  function automatic logic resp_is_error(input axi_resp_t resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/reg_to_axi_lite.sv
// Register-bus responder to AXI4-Lite manager bridge.
// Non-pipelined: one transaction in flight, all AXI outputs registered.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   reg_*               : register bus request in / one-cycle completion out
//   aw_*, w_*, b_*      : AXI-Lite write address, write data, write response
//   ar_*, r_*           : AXI-Lite read address, read data
module reg_to_axi_lite #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
  output logic                    reg_ready_o,
  output logic [DATA_WIDTH-1:0]   reg_rdata_o,
  output logic                    reg_error_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [2:0]              aw_prot_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [2:0]              ar_prot_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i
);
  import reg_to_axi_lite_pkg::*;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP, DONE
  } state_e;

  state_e state_q, state_d;
  logic   aw_done_q, w_done_q;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign aw_fire = aw_valid_o & aw_ready_i;
  assign w_fire  = w_valid_o  & w_ready_i;
  assign b_fire  = b_ready_o  & b_valid_i;
  assign ar_fire = ar_valid_o & ar_ready_i;
  assign r_fire  = r_ready_o  & r_valid_i;

  assign aw_prot_o = AXI_PROT;
  assign ar_prot_o = AXI_PROT;

  // AW and W may complete in either order; each counts once done or firing now.
  logic aw_ok, w_ok;
  assign aw_ok = aw_done_q | aw_fire;
  assign w_ok  = w_done_q  | w_fire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (reg_valid_i) state_d = reg_write_i ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_ok && w_ok) state_d = WR_RESP;
      WR_RESP:      if (b_fire) state_d = DONE;
      RD_ADDR:      if (ar_fire) state_d = RD_RESP;
      RD_RESP:      if (r_fire) state_d = DONE;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_valid_o  <= 1'b0;
      w_valid_o   <= 1'b0;
      ar_valid_o  <= 1'b0;
      b_ready_o   <= 1'b0;
      r_ready_o   <= 1'b0;
      reg_ready_o <= 1'b0;
      aw_addr_o   <= '0;
      ar_addr_o   <= '0;
      w_data_o    <= '0;
      w_strb_o    <= '0;
      reg_rdata_o <= '0;
      reg_error_o <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      // Ready/completion strobes are pure decodes of the next state, registered.
      b_ready_o   <= (state_d == WR_RESP);
      r_ready_o   <= (state_d == RD_RESP);
      reg_ready_o <= (state_d == DONE);
      case (state_q)
        IDLE: if (reg_valid_i) begin
          aw_addr_o  <= reg_addr_i;
          ar_addr_o  <= reg_addr_i;
          w_data_o   <= reg_wdata_i;
          w_strb_o   <= reg_wstrb_i;
          aw_valid_o <= reg_write_i;
          w_valid_o  <= reg_write_i;
          ar_valid_o <= ~reg_write_i;
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
        end
        WR_ADDR_DATA: begin
          if (aw_fire) begin
            aw_valid_o <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_fire) begin
            w_valid_o <= 1'b0;
            w_done_q  <= 1'b1;
          end
        end
        WR_RESP: if (b_fire) begin
          reg_rdata_o <= '0;
          reg_error_o <= resp_is_error(b_resp_i);
        end
        RD_ADDR: if (ar_fire) ar_valid_o <= 1'b0;
        RD_RESP: if (r_fire) begin
          reg_rdata_o <= r_data_i;
          reg_error_o <= resp_is_error(r_resp_i);
        end
        default: ;
      endcase
    end
  end

endmodule
